// File: rtl/uart_tx_irq.sv
// ---------------------------------------------------------------------------
// uart_tx_irq
//   Byte-wide UART transmitter (8N1, LSB first) with a small write FIFO fed
//   by the CPU store path. It raises a sticky, level frame-complete interrupt
//   that the register file mirrors into $k1[0] (uart_send cause).
//
//   Optional feature macro: UART_TX_PARITY_EN
//     defined   -> even parity bit inserted between the data bits and the stop bit
//                  (11 bit times per frame)
//     undefined -> strict 8N1 framing, no parity logic at all
//
// Parameters
//   CLK_DIV  clk cycles per bit (2..65535)
//   FIFO_AW  FIFO address width, depth = 2**FIFO_AW
//
// Ports
//   clk      in   system clock, rising edge
//   reset    in   asynchronous, active-low reset
//   wr_en    in   write strobe; pushes wr_data when full==0
//   wr_data  in   byte to transmit
//   irq_ack  in   one-cycle pulse that clears irq
//   tx       out  serial line, idle high (registered)
//   busy     out  frame on the line or FIFO non-empty
//   full     out  FIFO full; writes are dropped while high
//   irq      out  frame-complete interrupt, sticky until acknowledged
// ---------------------------------------------------------------------------
module uart_tx_irq #(
    parameter int unsigned CLK_DIV = 5208,
    parameter int unsigned FIFO_AW = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       wr_en,
    input  logic [7:0] wr_data,
    input  logic       irq_ack,
    output logic       tx,
    output logic       busy,
    output logic       full,
    output logic       irq
);

    localparam int unsigned          DEPTH     = 1 << FIFO_AW;
    localparam logic [FIFO_AW:0]     PTR_ONE   = {{FIFO_AW{1'b0}}, 1'b1};
    localparam logic [FIFO_AW:0]     FULL_CNT  = {1'b1, {FIFO_AW{1'b0}}};
    localparam logic [15:0]          BAUD_LAST = 16'(CLK_DIV - 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
`ifdef UART_TX_PARITY_EN
        PARITY = 3'd3,
`endif
        STOP   = 3'd4
    } state_t;

    state_t            state_q, state_d;
    logic [FIFO_AW:0]  wptr_q, wptr_d, rptr_q, rptr_d;
    logic [7:0]        mem_q [DEPTH];
    logic [15:0]       baud_cnt_q, baud_cnt_d;
    logic [2:0]        bit_cnt_q, bit_cnt_d;
    logic [7:0]        shreg_q, shreg_d;
    logic              tx_q, tx_d;
    logic              irq_q, irq_d;
`ifdef UART_TX_PARITY_EN
    logic              parity_q, parity_d;
`endif

    logic [FIFO_AW:0]  fifo_cnt;
    logic              empty, push, pop, baud_end, frame_done;

    // Flags come from registered pointers only, so busy/full never depend
    // combinationally on wr_en.
    assign fifo_cnt   = wptr_q - rptr_q;
    assign empty      = (wptr_q == rptr_q);
    assign full       = (fifo_cnt == FULL_CNT);
    // A push is refused while full, even if a pop frees a slot this cycle.
    assign push       = wr_en & ~full;
    assign pop        = (state_q == IDLE) & ~empty;
    assign baud_end   = (baud_cnt_q == BAUD_LAST);
    assign frame_done = (state_q == STOP) & baud_end;

    // ---------------- FSM: state register ----------------
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block ordering.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // ---------------- FSM: next state ----------------
    // NOTE: every combinational output gets a default first, so no path
    // leaves it unassigned and no latch is inferred.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:  if (!empty) state_d = START;
            START: if (baud_end) state_d = DATA;
`ifdef UART_TX_PARITY_EN
            DATA:   if (baud_end && bit_cnt_q == 3'd7) state_d = PARITY;
            PARITY: if (baud_end) state_d = STOP;
`else
            DATA:  if (baud_end && bit_cnt_q == 3'd7) state_d = STOP;
`endif
            STOP:  if (baud_end) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    // tx is registered from the current state, which puts the start bit on
    // the line one cycle after the pop and keeps the pin glitch-free.
    always_comb begin
        tx_d = 1'b1;
        case (state_q)
            START:  tx_d = 1'b0;
            DATA:   tx_d = shreg_q[0];
`ifdef UART_TX_PARITY_EN
            PARITY: tx_d = parity_q;
`endif
            default: tx_d = 1'b1;
        endcase
    end

    assign busy = (state_q != IDLE) | ~empty;
    assign tx   = tx_q;
    assign irq  = irq_q;

    // ---------------- datapath next state ----------------
    always_comb begin
        wptr_d     = push ? wptr_q + PTR_ONE : wptr_q;
        rptr_d     = pop  ? rptr_q + PTR_ONE : rptr_q;
        baud_cnt_d = baud_cnt_q;
        bit_cnt_d  = bit_cnt_q;
        shreg_d    = shreg_q;
`ifdef UART_TX_PARITY_EN
        parity_d   = parity_q;
`endif
        if (state_q == IDLE) begin
            baud_cnt_d = '0;
            if (pop) begin
                shreg_d  = mem_q[rptr_q[FIFO_AW-1:0]];
`ifdef UART_TX_PARITY_EN
                parity_d = ^mem_q[rptr_q[FIFO_AW-1:0]];
`endif
            end
        end else begin
            baud_cnt_d = baud_end ? 16'd0 : baud_cnt_q + 16'd1;
        end
        if (state_q == START && baud_end) bit_cnt_d = 3'd0;
        if (state_q == DATA && baud_end) begin
            shreg_d   = {1'b0, shreg_q[7:1]};
            bit_cnt_d = bit_cnt_q + 3'd1;
        end
        // Set wins over a simultaneous acknowledge.
        irq_d = frame_done | (irq_q & ~irq_ack);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wptr_q     <= '0;
            rptr_q     <= '0;
            baud_cnt_q <= '0;
            bit_cnt_q  <= '0;
            shreg_q    <= '0;
            tx_q       <= 1'b1;
            irq_q      <= 1'b0;
`ifdef UART_TX_PARITY_EN
            parity_q   <= 1'b0;
`endif
        end else begin
            wptr_q     <= wptr_d;
            rptr_q     <= rptr_d;
            baud_cnt_q <= baud_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            shreg_q    <= shreg_d;
            tx_q       <= tx_d;
            irq_q      <= irq_d;
`ifdef UART_TX_PARITY_EN
            parity_q   <= parity_d;
`endif
        end
    end

    // NOTE: FIFO storage has no reset; the pointers define which entries are
    // valid, so clearing the array would only cost reset fan-out.
    always_ff @(posedge clk) begin
        if (push) mem_q[wptr_q[FIFO_AW-1:0]] <= wr_data;
    end

endmodule

// File: tb/tb_uart_tx_irq.sv
// ---------------------------------------------------------------------------
// tb_uart_tx_irq
//   Self-checking bench for uart_tx_irq (CLK_DIV=4, FIFO_AW=2). A behavioural
//   model derives every output from the pop time of the current frame and a
//   byte queue; a line receiver decodes tx independently. Directed literal
//   sequences pin the model; a randomized phase stresses FIFO and irq.
//   Honours UART_TX_PARITY_EN.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_uart_tx_irq;

    localparam int CD    = 4;
    localparam int DEPTH = 4;
`ifdef UART_TX_PARITY_EN
    localparam int NB    = 11;
`else
    localparam int NB    = 10;
`endif
    localparam int FRAME = NB * CD;
    localparam int CLK_PERIOD = 10;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       wr_en = 1'b0;
    logic [7:0] wr_data = 8'h00;
    logic       irq_ack = 1'b0;
    logic       tx, busy, full, irq;

    int tests = 0;
    int fails = 0;

    uart_tx_irq #(.CLK_DIV(CD), .FIFO_AW(2)) dut (
        .clk     (clk),
        .reset   (rst_n),
        .wr_en   (wr_en),
        .wr_data (wr_data),
        .irq_ack (irq_ack),
        .tx      (tx),
        .busy    (busy),
        .full    (full),
        .irq     (irq)
    );

    always #(CLK_PERIOD/2) clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    // Line bit j of a frame carrying byte b: start, 8 data LSB first, [parity], stop.
    function automatic logic line_bit(input logic [7:0] b, input int j);
        if (j == 0) return 1'b0;
        if (j <= 8) return b[j-1];
`ifdef UART_TX_PARITY_EN
        if (j == 9) return ^b;
`endif
        return 1'b1;
    endfunction

    // ---------------- behavioural model ----------------
    logic [7:0] mq[$];        // bytes waiting in the FIFO
    logic [7:0] done_m[$];    // bytes whose frame completed
    logic [7:0] cur_m = 8'h00;
    bit         have_frame = 1'b0;
    bit         irq_m = 1'b0;
    longint     pop_cyc = 0;
    longint     e_last = 0;
    longint     e_now = 0;
    bit         idle_pre, full_pre;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mq.delete();
            have_frame = 1'b0;
            irq_m      = 1'b0;
        end else begin
            e_now    = longint'($time / CLK_PERIOD);
            // Transmitter is idle before this edge once the previous frame's
            // last edge (pop + FRAME) has passed.
            idle_pre = !have_frame || (e_now > pop_cyc + FRAME);
            full_pre = (mq.size() == DEPTH);
            if (have_frame && e_now == pop_cyc + FRAME) begin
                irq_m = 1'b1;
                done_m.push_back(cur_m);
            end else if (irq_ack) begin
                irq_m = 1'b0;
            end
            if (idle_pre && mq.size() != 0) begin
                cur_m      = mq.pop_front();
                pop_cyc    = e_now;
                have_frame = 1'b1;
            end
            if (wr_en && !full_pre) mq.push_back(wr_data);
            e_last = e_now;
        end
    end

    // ---------------- compare process ----------------
    bit     chk_en = 1'b0;
    longint k_rel;
    logic   exp_tx, exp_busy;

    always @(negedge clk) begin
        if (chk_en) begin
            k_rel    = e_last - 1 - pop_cyc;   // tx lags the frame by one cycle
            exp_tx   = (have_frame && k_rel >= 0 && k_rel < FRAME) ?
                       line_bit(cur_m, int'(k_rel / CD)) : 1'b1;
            exp_busy = (have_frame && e_last < pop_cyc + FRAME) || (mq.size() != 0);
            check("model_tx",   {31'd0, tx},   {31'd0, exp_tx});
            check("model_busy", {31'd0, busy}, {31'd0, exp_busy});
            check("model_full", {31'd0, full}, {31'd0, (mq.size() == DEPTH)});
            check("model_irq",  {31'd0, irq},  {31'd0, irq_m});
        end
    end

    // ---------------- independent line receiver ----------------
    logic [7:0] rx_q[$];
    logic       rx_prev = 1'b1;
    logic [7:0] rx_byte;
    bit         rx_ok;

    initial begin : rx_mon
        forever begin
            @(negedge clk);
            if (rst_n && rx_prev && !tx) begin
                rx_ok   = 1'b1;
                rx_byte = 8'h00;
                for (int j = 0; j < NB - 1; j++) begin
                    repeat (CD) begin
                        @(negedge clk);
                        if (!rst_n) rx_ok = 1'b0;
                    end
                    if (j < 8) rx_byte[j] = tx;
`ifdef UART_TX_PARITY_EN
                    else if (j == 8 && rx_ok) check("rx_parity", {31'd0, tx}, {31'd0, ^rx_byte});
`endif
                    else if (rx_ok) check("rx_stop", {31'd0, tx}, 32'd1);
                end
                if (rx_ok) rx_q.push_back(rx_byte);
            end
            rx_prev = tx;
        end
    end

    // ---------------- helpers ----------------
    task automatic wait_idle(input string name);
        int n;
        n = 0;
        while (busy && n < 20 * FRAME) begin
            @(posedge clk);
            n++;
        end
        check(name, {31'd0, busy}, 32'd0);
        repeat (4) @(posedge clk);
        #1;
    endtask

    // Write one byte into an idle block and compare every line bit against
    // a hand-written sequence (index 0 = start bit).
    task automatic frame_literal(input logic [7:0] b, input logic [NB-1:0] exp);
        @(posedge clk); #1;
        irq_ack = 1'b1; wr_en = 1'b1; wr_data = b;
        @(posedge clk); #1;          // edge N samples the write
        irq_ack = 1'b0; wr_en = 1'b0;
        @(posedge clk);              // N+1: pop
        @(posedge clk);              // N+2: start bit reaches the pin
        for (int i = 0; i < NB; i++) begin
            @(negedge clk);
            check("lit_bit", {31'd0, tx}, {31'd0, exp[i]});
            if (i == 0)      check("lit_busy_start", {31'd0, busy}, 32'd1);
            if (i == NB - 1) check("lit_irq_before", {31'd0, irq},  32'd0);
            repeat (CD - 1) @(negedge clk);
        end
        check("lit_irq_after",  {31'd0, irq},  32'd1);
        check("lit_busy_after", {31'd0, busy}, 32'd0);
    endtask

    int rx_before;

    initial begin
        // ---- reset state ----
        repeat (3) @(posedge clk);
        #1;
        check("rst_tx",   {31'd0, tx},   32'd1);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_full", {31'd0, full}, 32'd0);
        check("rst_irq",  {31'd0, irq},  32'd0);
        rst_n = 1'b1;
        chk_en = 1'b1;
        repeat (2) @(posedge clk);

        // ---- single frame 8'hA5, literal line sequence ----
`ifdef UART_TX_PARITY_EN
        frame_literal(8'hA5, 11'b10101001010);
        wait_idle("idle_a5");
        frame_literal(8'h07, 11'b11000001110);   // parity 1
        wait_idle("idle_07");
        frame_literal(8'h03, 11'b10000000110);   // parity 0
`else
        frame_literal(8'hA5, 10'b1101001010);
`endif
        wait_idle("idle_lit");

        // ---- ack on an idle cycle clears irq at the next edge ----
        @(posedge clk); #1 irq_ack = 1'b1;
        @(posedge clk); #1 irq_ack = 1'b0;
        check("ack_idle", {31'd0, irq}, 32'd0);

        // ---- six consecutive writes: five accepted, sixth dropped ----
        rx_before = rx_q.size();
        for (int i = 0; i < 6; i++) begin
            wr_en = 1'b1;
            wr_data = 8'(8'h11 + i);
            @(posedge clk); #1;
            if (i >= 4) check("burst_full", {31'd0, full}, 32'd1);
        end
        wr_en = 1'b0;
        wait_idle("idle_burst");
        check("burst_count", rx_q.size() - rx_before, 32'd5);
        for (int i = 0; i < 5; i++)
            if (rx_before + i < rx_q.size())
                check("burst_order", {24'd0, rx_q[rx_before + i]}, 32'(8'h11 + i));

        // ---- two frames, irq stays set without ack ----
        for (int i = 0; i < 2; i++) begin
            wr_en = 1'b1; wr_data = 8'(8'hC3 + i);
            @(posedge clk); #1;
        end
        wr_en = 1'b0;
        wait_idle("idle_two");
        check("two_irq_sticky", {31'd0, irq}, 32'd1);

        // ---- ack coincident with STOP end: set wins ----
        wr_en = 1'b1; wr_data = 8'h5A;
        @(posedge clk); #1;            // edge N
        wr_en = 1'b0;
        repeat (FRAME) @(posedge clk); // now at edge N+FRAME
        #1 irq_ack = 1'b1;
        @(posedge clk); #1;            // edge N+1+FRAME: STOP end
        irq_ack = 1'b0;
        check("ack_vs_set_irq",  {31'd0, irq},  32'd1);
        check("ack_vs_set_busy", {31'd0, busy}, 32'd0);
        @(posedge clk); #1 irq_ack = 1'b1;
        @(posedge clk); #1 irq_ack = 1'b0;
        check("ack_after", {31'd0, irq}, 32'd0);
        wait_idle("idle_ack");

        // ---- reset 12 clks into a frame, with more bytes queued ----
        for (int i = 0; i < 3; i++) begin
            wr_en = 1'b1; wr_data = 8'(8'h80 + i);
            @(posedge clk); #1;
        end
        wr_en = 1'b0;
        repeat (10) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        check("midrst_tx",   {31'd0, tx},   32'd1);
        check("midrst_busy", {31'd0, busy}, 32'd0);
        check("midrst_full", {31'd0, full}, 32'd0);
        check("midrst_irq",  {31'd0, irq},  32'd0);
        rx_before = rx_q.size();
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (3 * FRAME) @(posedge clk);
        #1;
        check("postrst_busy", {31'd0, busy}, 32'd0);
        check("postrst_rx",   rx_q.size() - rx_before, 32'd0);

        // ---- randomized traffic ----
        for (int seg = 0; seg < 4; seg++) begin
            for (int c = 0; c < 800; c++) begin
                @(posedge clk); #1;
                wr_en   = ($urandom_range(0, 7) < 1 + 2 * seg % 7);
                wr_data = 8'($urandom);
                irq_ack = ($urandom_range(0, 9) == 0);
            end
        end
        @(posedge clk); #1;
        wr_en = 1'b0; irq_ack = 1'b0;
        wait_idle("idle_random");
        repeat (2 * CD) @(posedge clk);

        // ---- end-to-end: decoded line equals completed frames in order ----
        check("e2e_count", rx_q.size(), done_m.size());
        for (int i = 0; i < rx_q.size() && i < done_m.size(); i++)
            check("e2e_byte", {24'd0, rx_q[i]}, {24'd0, done_m[i]});

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
